// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 constants, frame width and transmitter state encoding.
// Used by ps2_tx, ps2_clk_filter and the companion ps2_rx.
`default_nettype none

package ps2_pkg;

  localparam int PS2_DATA_BITS      = 8;
  localparam int PS2_INHIBIT_CYCLES = 6000;
  localparam int PS2_FILTER_LEN     = 8;
  localparam int PS2_TIMEOUT_CYCLES = 1000000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RTS   = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_ACK   = 3'd4
  } ps2_tx_state_e;

  // PS/2 frames carry odd parity: data plus parity has an odd number of ones.
  function automatic logic ps2_odd_parity(input logic [PS2_DATA_BITS-1:0] i_d);
    return ~^i_d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: 2-flop synchronizer, FILTER_LEN-tap glitch filter and a
// registered one-cycle tick on every filtered 1->0 transition of the PS/2 clock.
`default_nettype none

module ps2_clk_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_line,
  output logic o_fall
);

  logic [1:0]            r_sync;
  logic [FILTER_LEN-1:0] r_taps;
  logic                  r_level;
  logic                  r_fall;
  logic                  w_all_hi;
  logic                  w_all_lo;

  assign w_all_hi = &r_taps;
  assign w_all_lo = ~|r_taps;

  // An idle PS/2 bus floats high, so the pipeline resets to the released level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync  <= 2'b11;
      r_taps  <= '1;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_line};
      r_taps <= {r_taps[FILTER_LEN-2:0], r_sync[1]};
      if (w_all_hi) begin
        r_level <= 1'b1;
      end else if (w_all_lo) begin
        r_level <= 1'b0;
      end
      r_fall <= r_level & w_all_lo;
    end
  end

  assign o_fall = r_fall;

endmodule

`default_nettype wire

// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device command transmitter (inhibit, start, 8 data, parity,
// stop, ack). Optional frame watchdog enabled by defining PS2_TX_TIMEOUT_EN.
`default_nettype none

module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int FILTER_LEN     = PS2_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err
);

  localparam int c_INH_W = $clog2(INHIBIT_CYCLES + 1);

  localparam logic [2:0] c_IDLE  = ST_IDLE;
  localparam logic [2:0] c_RTS   = ST_RTS;
  localparam logic [2:0] c_START = ST_START;
  localparam logic [2:0] c_DATA  = ST_DATA;
  localparam logic [2:0] c_ACK   = ST_ACK;

  logic [2:0]             r_state;
  logic [c_INH_W-1:0]     r_rts_cnt;
  logic [PS2_DATA_BITS:0] r_shift;
  logic [3:0]             r_bit_cnt;
  logic [1:0]             r_dsync;
  logic                   r_done;
  logic                   r_err;
  logic                   w_fall;
  logic                   w_busy;
  logic                   w_wdog_exp;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk   (clk),
    .resetn(resetn),
    .i_line(ps2c),
    .o_fall(w_fall)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dsync <= 2'b11;
    end else begin
      r_dsync <= {r_dsync[0], ps2d};
    end
  end

  // States in which the device owns the clock and frame progress depends on it.
  assign w_busy = (r_state == c_START) || (r_state == c_DATA) || (r_state == c_ACK);

`ifdef PS2_TX_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_TO_W-1:0] r_wdog;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wdog <= '0;
    end else if (w_busy && !w_fall) begin
      r_wdog <= r_wdog + 1'b1;
    end else begin
      r_wdog <= '0;
    end
  end

  assign w_wdog_exp = w_busy && (r_wdog == c_TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_wdog_exp = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= c_IDLE;
      r_rts_cnt <= '0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_wdog_exp) begin
        r_state <= c_IDLE;
        r_err   <= 1'b1;
        r_done  <= 1'b1;
      end else begin
        case (r_state)
          c_IDLE: begin
            if (wr_ps2) begin
              r_shift   <= {ps2_odd_parity(din), din};
              r_err     <= 1'b0;
              r_rts_cnt <= '0;
              r_state   <= c_RTS;
            end
          end
          c_RTS: begin
            if (r_rts_cnt == c_INH_W'(INHIBIT_CYCLES - 1)) begin
              r_state <= c_START;
            end else begin
              r_rts_cnt <= r_rts_cnt + 1'b1;
            end
          end
          c_START: begin
            if (w_fall) begin
              r_bit_cnt <= '0;
              r_state   <= c_DATA;
            end
          end
          c_DATA: begin
            // Counter reaches PS2_DATA_BITS once parity is on the line; next fall is the stop bit.
            if (w_fall) begin
              if (r_bit_cnt == 4'(PS2_DATA_BITS)) begin
                r_state <= c_ACK;
              end else begin
                r_shift   <= {1'b1, r_shift[PS2_DATA_BITS:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
          end
          c_ACK: begin
            if (w_fall) begin
              r_err   <= r_dsync[1];
              r_done  <= 1'b1;
              r_state <= c_IDLE;
            end
          end
          default: begin
            r_state <= c_IDLE;
          end
        endcase
      end
    end
  end

  assign tx_idle      = (r_state == c_IDLE);
  assign ps2c_oe      = (r_state == c_RTS);
  assign ps2d_oe      = (r_state == c_START) || ((r_state == c_DATA) && !r_shift[0]);
  assign tx_done_tick = r_done;
  assign tx_err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: randomized self-checking bench with an open-drain PS/2 keyboard model.
`default_nettype none

module tb_ps2_tx;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int c_TO = 20000;
`else
  localparam int c_TO = 1000000;
`endif
  localparam int c_INH  = 6000;
  localparam int c_HALF = 40;

  logic       clk = 1'b0;
  logic       resetn;
  logic       wr_ps2;
  logic [7:0] din;
  logic       dev_clk;
  logic       dev_data;
  wire        ps2c;
  wire        ps2d;
  wire        ps2c_oe;
  wire        ps2d_oe;
  wire        tx_idle;
  wire        tx_done_tick;
  wire        tx_err;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int err_at_done = 0;
  int idle_at_done = 0;
  int run = 0;
  int last_run = 0;

  assign ps2c = dev_clk & ~ps2c_oe;
  assign ps2d = dev_data & ~ps2d_oe;

  always #5 clk = ~clk;

  ps2_tx #(
    .INHIBIT_CYCLES(c_INH),
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(c_TO)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .wr_ps2      (wr_ps2),
    .din         (din),
    .ps2c        (ps2c),
    .ps2d        (ps2d),
    .ps2c_oe     (ps2c_oe),
    .ps2d_oe     (ps2d_oe),
    .tx_idle     (tx_idle),
    .tx_done_tick(tx_done_tick),
    .tx_err      (tx_err)
  );

  always @(negedge clk) begin
    if (tx_done_tick) begin
      done_cnt++;
      err_at_done  = tx_err;
      idle_at_done = tx_idle;
    end
    if (ps2c_oe) begin
      run++;
    end else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line view of a frame: bit0 start, bits 8:1 data LSB first, bit9 odd parity, bit10 stop.
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    logic p;
    p = ($countones(d) % 2 == 0);
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic wait_request(output bit ok);
    int guard = 0;
    while (ps2c_oe && guard < c_INH + 100) begin
      @(negedge clk);
      guard++;
    end
    ok = !ps2c_oe;
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit ack, input int inject_at, input int abort_at);
    int d0;
    bit ok;
    logic [10:0] rx;
    d0 = done_cnt;
    rx = '0;
    wr_ps2 = 1'b1;
    din = d;
    @(negedge clk);
    wr_ps2 = 1'b0;
    din = 8'($urandom);
    check("accept_busy", tx_idle, 0);
    check("rts_clk_oe", ps2c_oe, 1);
    check("rts_dat_oe", ps2d_oe, 0);
    check("err_clr_on_write", tx_err, 0);
    wait_request(ok);
    if (!ok) begin
      check("rts_never_ends", 0, 1);
      return;
    end
    check("inhibit_len", last_run, c_INH);
    check("start_dat_oe", ps2d_oe, 1);
    rx[0] = ps2d;
    repeat (30) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      dev_clk = 1'b0;
      if (k == abort_at) begin
        repeat (20) @(negedge clk);
        #3 resetn = 1'b0;
        #1;
        check("abort_clk_oe", ps2c_oe, 0);
        check("abort_dat_oe", ps2d_oe, 0);
        check("abort_idle", tx_idle, 1);
        check("abort_err", tx_err, 0);
        @(negedge clk);
        resetn = 1'b1;
        dev_clk = 1'b1;
        dev_data = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        return;
      end
      repeat (c_HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (k <= 10) rx[k] = ps2d;
      if (k == 10) dev_data = ack ? 1'b0 : 1'b1;
      if (k == inject_at) begin
        wr_ps2 = 1'b1;
        din = 8'h55;
      end
      @(negedge clk);
      wr_ps2 = 1'b0;
      repeat (c_HALF - 1) @(negedge clk);
    end
    dev_data = 1'b1;
    repeat (5) @(negedge clk);
    check("frame_bits", rx, ref_frame(d));
    check("done_once", done_cnt - d0, 1);
    check("err_at_done", err_at_done, !ack);
    check("idle_at_done", idle_at_done, 1);
    check("err_hold", tx_err, !ack);
    check("no_new_frame", ps2c_oe, 0);
  endtask

  initial begin
    resetn = 1'b0;
    wr_ps2 = 1'b0;
    din = 8'h00;
    dev_clk = 1'b1;
    dev_data = 1'b1;
    #2;
    check("rst_clk_oe", ps2c_oe, 0);
    check("rst_dat_oe", ps2d_oe, 0);
    check("rst_idle", tx_idle, 1);
    check("rst_done", tx_done_tick, 0);
    check("rst_err", tx_err, 0);
    for (int i = 0; i < 4; i++) begin
      dev_clk = ~dev_clk;
      repeat (20) @(negedge clk);
      check("rst_clocking_oe", {30'd0, ps2c_oe, ps2d_oe}, 0);
    end
    resetn = 1'b1;
    dev_clk = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dev_clk = ~dev_clk;
      repeat (20) @(negedge clk);
    end
    check("idle_falls_oe", {30'd0, ps2c_oe, ps2d_oe}, 0);
    check("idle_falls_idle", tx_idle, 1);
    check("idle_falls_done", done_cnt, 0);

    send_frame(8'hED, 1'b1, -1, -1);
    send_frame(8'h00, 1'b1, -1, -1);
    send_frame(8'h01, 1'b1, -1, -1);
    send_frame(8'($urandom), 1'b0, -1, -1);
    send_frame(8'($urandom), 1'b1, -1, -1);
    send_frame(8'hF0, 1'b1, 4, -1);
    send_frame(8'($urandom), 1'b1, -1, 5);
    send_frame(8'($urandom), $urandom_range(0, 1) == 1, -1, -1);

`ifdef PS2_TX_TIMEOUT_EN
    begin
      int d0;
      int guard;
      bit ok;
      d0 = done_cnt;
      wr_ps2 = 1'b1;
      din = 8'($urandom);
      @(negedge clk);
      wr_ps2 = 1'b0;
      wait_request(ok);
      check("wd_request", ok, 1);
      guard = 0;
      while (done_cnt == d0 && guard < c_TO + 200) begin
        @(negedge clk);
        guard++;
      end
      check("wd_fired", done_cnt - d0, 1);
      check("wd_err", err_at_done, 1);
      check("wd_lines", {30'd0, ps2c_oe, ps2d_oe}, 0);
      check("wd_idle", tx_idle, 1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
